// File: rtl/reg_write_port.sv
// reg_write_port: write port of a 32 x 32-bit register file with a hardwired-zero register 0.
//
// Ports:
//   clk         - single clock, all state updates on its rising edge
//   rst         - synchronous active-high reset
//   wr_en       - write request
//   wr_addr     - destination register index (0..31)
//   wr_data     - write data
//   regs_out    - all registers flattened, register k at [32*k+31:32*k]
//   dec_out     - combinational one-hot decode of wr_addr gated by wr_en
//   wr_ack      - one-cycle pulse after each committed write
//   wr_ack_addr - index of the most recently committed write
//   wr_count    - committed writes since reset, wraps at 16 bits
module reg_write_port (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [4:0]     wr_addr,
    input  logic [31:0]    wr_data,
    output logic [1023:0]  regs_out,
    output logic [31:0]    dec_out,
    output logic           wr_ack,
    output logic [4:0]     wr_ack_addr,
    output logic [15:0]    wr_count
);

    // Register 0 has no storage; it is tied to zero on regs_out.
    logic [31:0] regs_q [1:31];
    logic        wr_ack_q;
    logic        wr_ack_d;
    logic [4:0]  wr_ack_addr_q;
    logic [4:0]  wr_ack_addr_d;
    logic [15:0] wr_count_q;
    logic [15:0] wr_count_d;

    // Demux tree, MSB at the root and LSB at the leaves, so leaf index equals wr_addr.
    logic [1:0]  lvl1;
    logic [3:0]  lvl2;
    logic [7:0]  lvl3;
    logic [15:0] lvl4;
    logic        commit;

    always_comb begin
        lvl1 = {wr_en & wr_addr[4], wr_en & ~wr_addr[4]};
        lvl2 = '0;
        lvl3 = '0;
        lvl4 = '0;
        dec_out = '0;
        for (int i = 0; i < 2; i++) begin
            lvl2[2*i+1] = lvl1[i] & wr_addr[3];
            lvl2[2*i]   = lvl1[i] & ~wr_addr[3];
        end
        for (int i = 0; i < 4; i++) begin
            lvl3[2*i+1] = lvl2[i] & wr_addr[2];
            lvl3[2*i]   = lvl2[i] & ~wr_addr[2];
        end
        for (int i = 0; i < 8; i++) begin
            lvl4[2*i+1] = lvl3[i] & wr_addr[1];
            lvl4[2*i]   = lvl3[i] & ~wr_addr[1];
        end
        for (int i = 0; i < 16; i++) begin
            dec_out[2*i+1] = lvl4[i] & wr_addr[0];
            dec_out[2*i]   = lvl4[i] & ~wr_addr[0];
        end
    end

    // Writes to index 0 are dropped and never acknowledged or counted.
    assign commit = |dec_out[31:1];

    always_comb begin
        wr_ack_d      = commit;
        wr_ack_addr_d = wr_ack_addr_q;
        wr_count_d    = wr_count_q;
        if (commit) begin
            wr_ack_addr_d = wr_addr;
            wr_count_d    = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < 32; k++) begin
                regs_q[k] <= '0;
            end
            wr_ack_q      <= 1'b0;
            wr_ack_addr_q <= '0;
            wr_count_q    <= '0;
        end else begin
            for (int k = 1; k < 32; k++) begin
                if (dec_out[k]) begin
                    regs_q[k] <= wr_data;
                end
            end
            wr_ack_q      <= wr_ack_d;
            wr_ack_addr_q <= wr_ack_addr_d;
            wr_count_q    <= wr_count_d;
        end
    end

    always_comb begin
        regs_out = '0;
        for (int k = 1; k < 32; k++) begin
            regs_out[32*k +: 32] = regs_q[k];
        end
    end

    assign wr_ack      = wr_ack_q;
    assign wr_ack_addr = wr_ack_addr_q;
    assign wr_count    = wr_count_q;

endmodule

// File: doc/reg_write_port.md
REG_WRITE_PORT -- requirements
Module: reg_write_port

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have the port wr_en, input, 1 bit: write request, sampled at the rising edge of clk.
REQ-004 The block SHALL have the port wr_addr, input, 5 bits: destination register index, 0 to 31.
REQ-005 The block SHALL have the port wr_data, input, 32 bits: write data.
REQ-006 The block SHALL have the port regs_out, output, 1024 bits: the contents of all registers, flattened.
 - regs_out[32*k+31 : 32*k] holds register k.
 - Each 32-bit slice feeds input k of the 32-way 32-bit read selector.
REQ-007 The block SHALL have the port dec_out, output, 32 bits: one-hot decode of wr_addr, gated by wr_en; combinational.
REQ-008 The block SHALL have the port wr_ack, output, 1 bit: registered pulse indicating that a write was committed in the previous cycle.
REQ-009 The block SHALL have the port wr_ack_addr, output, 5 bits: the index of the most recently committed write.
REQ-010 The block SHALL have the port wr_count, output, 16 bits: the number of committed writes since reset.

Function
REQ-011 The block SHALL hold 32 registers of 32 bits each.
REQ-012 dec_out[k] SHALL be 1 when wr_en=1 and wr_addr=k, and 0 otherwise.
 - dec_out has at most one bit set.
 - The decode is built as a 5-level tree of 1-to-2 demux stages, one stage per wr_addr bit, LSB at the leaves.
REQ-013 On a rising edge with rst=0, wr_en=1 and wr_addr=k, k≠0: register k SHALL load wr_data; all other registers SHALL hold.
REQ-014 Register 0 SHALL always read 0x00000000.
 - A write to index 0 is discarded.
 - It is not counted as committed: wr_ack stays 0 and wr_count is unchanged.
REQ-015 A committed write SHALL be visible on regs_out in the cycle after the edge: write latency 1 cycle, no bypass of wr_data to regs_out.
REQ-016 When wr_en=0, no register, wr_ack_addr or wr_count SHALL change, and wr_ack SHALL be 0 in the next cycle.
REQ-017 wr_ack SHALL be 1 for exactly one cycle after each committed write.
 - Back-to-back committed writes hold wr_ack high continuously.
REQ-018 wr_ack_addr SHALL update to k on each committed write and hold otherwise.
REQ-019 wr_count SHALL increment by 1 per committed write and wrap from 0xFFFF to 0x0000 with no flag.
REQ-020 Writing the same register on consecutive cycles SHALL leave the last written value.
REQ-021 X or Z on wr_addr while wr_en=0 SHALL NOT alter state.

Reset
REQ-022 When rst=1 at a rising edge of clk, the block SHALL clear all 32 registers to 0x00000000, wr_ack to 0, wr_ack_addr to 0 and wr_count to 0.
REQ-023 rst SHALL take priority over a simultaneous wr_en=1: the write is dropped and not counted.
REQ-024 Reset asserted mid-sequence SHALL take effect at the next edge; the following edge with rst=0 SHALL accept a new write normally.
REQ-025 dec_out SHALL remain combinational and unaffected by rst.

Verification
REQ-026 Reset: rst=1 for 2 cycles -> all regs_out=0, wr_ack=0, wr_count=0.
REQ-027 Single write: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF for 1 cycle ->
 - dec_out=0x00000020 during the cycle;
 - next cycle: regs_out slice 5=0xDEADBEEF, wr_ack=1, wr_ack_addr=5, wr_count=1;
 - all other slices=0.
REQ-028 Zero register: write 0xFFFFFFFF to index 0 -> slice 0 stays 0, wr_ack=0, wr_count unchanged, dec_out=0x00000001 during the cycle.
REQ-029 Sweep: write k*0x01010101 to indices 1..31 on consecutive cycles ->
 - wr_ack held high for 31 cycles;
 - final wr_count=31;
 - each slice k=k*0x01010101.
REQ-030 Reset collision: rst=1 with wr_en=1, wr_addr=3, wr_data=0x12345678 -> slice 3=0, wr_count=0, wr_ack=0.
REQ-031 Wrap: preload the counter via 65536 writes to index 7 -> wr_count=0x0000 and slice 7 holds the last data.
